// File: rtl/stack_unit_pkg.sv
// ---------------------------------------------------------------------------
// stack_unit_pkg
// Shared definitions for the stack unit: opcode encoding and default
// geometry. Imported by stack_unit and stack_alu.
// ---------------------------------------------------------------------------
package stack_unit_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // Codes 5..7 are deliberately left unnamed; they decode as illegal.
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4
  } op_e;

endpackage

// File: rtl/stack_alu.sv
// ---------------------------------------------------------------------------
// stack_alu
// Purely combinational two's-complement add/subtract used by the stack unit.
// Ports:
//   i_a        - earlier-pushed operand (entry below top)
//   i_b        - later-pushed operand (top of stack)
//   i_sub      - 1: a - b, 0: a + b
//   o_result   - wrap-around result, WIDTH bits
//   o_overflow - signed overflow of the selected operation
// ---------------------------------------------------------------------------
module stack_alu
  import stack_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_result,
  output logic             o_overflow
);

  logic w_same_sign;

  always_comb begin
    o_result    = i_sub ? (i_a - i_b) : (i_a + i_b);
    w_same_sign = (i_a[WIDTH-1] == i_b[WIDTH-1]);
    // Add overflows only for like-signed operands, subtract only for
    // unlike-signed ones; in both cases the result sign departs from a.
    o_overflow  = (i_sub ? !w_same_sign : w_same_sign) &&
                  (o_result[WIDTH-1] != i_a[WIDTH-1]);
  end

endmodule

// File: rtl/stack_unit.sv
// ---------------------------------------------------------------------------
// stack_unit
// Small signed operand stack with PUSH/POP/ADD/SUB, one operation per cycle,
// results visible one cycle after the operation is sampled.
// Ports:
//   clk        - clock, rising edge active
//   reset      - asynchronous active-low reset
//   op_valid   - operation request qualifier
//   op         - opcode (see stack_unit_pkg::op_e; 5..7 illegal)
//   din        - operand for PUSH
//   top        - registered top-of-stack, 0 when empty
//   dout       - value removed by the last successful POP
//   dout_valid - one-cycle pulse after a successful POP
//   count      - occupied entries
//   empty/full - count == 0 / count == DEPTH
//   op_err     - one-cycle pulse after a faulting operation
//   error      - sticky OR of op_err, cleared only by reset
// ---------------------------------------------------------------------------
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       op_valid,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           top,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       op_err,
  output logic                       error
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_top;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_op_err;
  logic             r_error;

  op_e              w_op;
  logic [AW-1:0]    w_idx_free;   // slot above top (PUSH target)
  logic [AW-1:0]    w_idx_next;   // entry directly below top
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_ovf;
  logic             w_empty;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_do_arith;
  logic             w_fault;

  assign w_op       = op_e'(op);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_idx_free = AW'(r_count);
  // Wraps when count < 2; the value read is then never used.
  assign w_idx_next = AW'(r_count - CW'(2));
  assign w_next     = r_stack[w_idx_next];

  // r_top mirrors the entry at count-1, so it serves directly as operand b.
  stack_alu #(.WIDTH(WIDTH)) u_alu (
    .i_a        (w_next),
    .i_b        (r_top),
    .i_sub      (w_op == OP_SUB),
    .o_result   (w_alu_result),
    .o_overflow (w_alu_ovf)
  );

  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    w_do_push  = 1'b0;
    w_do_pop   = 1'b0;
    w_do_arith = 1'b0;
    w_fault    = 1'b0;
    if (op_valid) begin
      case (w_op)
        OP_NOP:  ;
        OP_PUSH: begin
          w_do_push = !w_full;
          w_fault   = w_full;
        end
        OP_POP: begin
          w_do_pop = !w_empty;
          w_fault  = w_empty;
        end
        OP_ADD, OP_SUB: begin
          // Overflowing results are still written; only the flag is raised.
          w_do_arith = (r_count >= CW'(2));
          w_fault    = !w_do_arith || w_alu_ovf;
        end
        default: w_fault = 1'b1;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count      <= '0;
      r_top        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_op_err     <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_dout_valid <= w_do_pop;
      r_op_err     <= w_fault;
      r_error      <= r_error | w_fault;
      if (w_do_push) begin
        r_count <= r_count + CW'(1);
        r_top   <= din;
      end else if (w_do_pop) begin
        r_count <= r_count - CW'(1);
        r_dout  <= r_top;
        r_top   <= (r_count >= CW'(2)) ? w_next : '0;
      end else if (w_do_arith) begin
        r_count <= r_count - CW'(1);
        r_top   <= w_alu_result;
      end
    end
  end

  // NOTE: the storage array has no reset on purpose; entries at or above
  // count are never read into top, so stale data cannot become visible.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_stack[w_idx_free] <= din;
    end else if (w_do_arith) begin
      r_stack[w_idx_next] <= w_alu_result;
    end
  end

  assign top        = r_top;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign count      = r_count;
  assign empty      = w_empty;
  assign full       = w_full;
  assign op_err     = r_op_err;
  assign error      = r_error;

endmodule

// File: tb/tb_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_stack_unit
// Directed bench for stack_unit. A driver issues one operation per cycle and
// queues the hand-computed expected outputs; a monitor pops and compares
// shortly after each rising edge.
// ---------------------------------------------------------------------------
module tb_stack_unit;
  import stack_unit_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             op_valid = 1'b0;
  logic [2:0]       op = 3'd0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             op_err;
  logic             error;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op         (op),
    .din        (din),
    .top        (top),
    .dout       (dout),
    .dout_valid (dout_valid),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .op_err     (op_err),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    top;
    int    count;
    bit    dv;
    int    dout;
    bit    err;
    bit    error;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   m_dout = 0;     // last popped value, persists across operations
  bit   m_error = 1'b0; // sticky error expectation

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare the outputs produced by the operation sampled at this edge.
  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, ".top"},        $signed(top),       mon_e.top);
      check({mon_e.tag, ".count"},      count,              mon_e.count);
      check({mon_e.tag, ".empty"},      empty,              mon_e.count == 0);
      check({mon_e.tag, ".full"},       full,               mon_e.count == DEPTH);
      check({mon_e.tag, ".dout_valid"}, dout_valid,         mon_e.dv);
      check({mon_e.tag, ".dout"},       $signed(dout),      mon_e.dout);
      check({mon_e.tag, ".op_err"},     op_err,             mon_e.err);
      check({mon_e.tag, ".error"},      error,              mon_e.error);
    end
  end

  task automatic issue(input string tag, input bit v, input logic [2:0] o,
                       input int d, input int et, input int ec, input bit eerr,
                       input bit edv = 1'b0, input int edout = 0);
    exp_t e;
    @(negedge clk);
    op_valid = v;
    op       = o;
    din      = WIDTH'(d);
    if (edv) m_dout = edout;
    m_error = m_error | eerr;
    e.tag = tag; e.top = et; e.count = ec; e.dv = edv;
    e.dout = m_dout; e.err = eerr; e.error = m_error;
    sb.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".top"},        $signed(top), 0);
    check({tag, ".count"},      count,        0);
    check({tag, ".dout"},       $signed(dout), 0);
    check({tag, ".dout_valid"}, dout_valid,   0);
    check({tag, ".op_err"},     op_err,       0);
    check({tag, ".error"},      error,        0);
    check({tag, ".empty"},      empty,        1);
    check({tag, ".full"},       full,         0);
  endtask

  // Asserts reset between clock edges and checks outputs before any edge.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    op_valid = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_vals(tag);
    m_dout  = 0;
    m_error = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #3 check_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;

    // Program flow
    issue("prog.push5",  1, OP_PUSH, 5,  5,  1, 0);
    issue("prog.push23", 1, OP_PUSH, 23, 23, 2, 0);
    issue("prog.add1",   1, OP_ADD,  77, 28, 1, 0);
    issue("prog.push28", 1, OP_PUSH, 28, 28, 2, 0);
    issue("prog.add2",   1, OP_ADD,  0,  56, 1, 0);
    issue("prog.push12", 1, OP_PUSH, 12, 12, 2, 0);
    issue("prog.sub",    1, OP_SUB,  -1, 44, 1, 0);
    issue("prog.pop",    1, OP_POP,  99, 0,  0, 0, 1, 44);
    issue("prog.idle",   0, OP_NOP,  0,  0,  0, 0);

    // Signed overflow on ADD
    issue("ovf.push_a", 1, OP_PUSH, 100, 100, 1, 0);
    issue("ovf.push_b", 1, OP_PUSH, 100, 100, 2, 0);
    issue("ovf.add",    1, OP_ADD,  0,   -56, 1, 1);
    issue("ovf.idle",   0, OP_NOP,  0,   -56, 1, 0);
    issue("ovf.pop",    1, OP_POP,  0,   0,   0, 0, 1, -56);

    // Full stack
    apply_reset("rst1");
    for (int i = 1; i <= DEPTH; i++) issue("full.push", 1, OP_PUSH, i, i, i, 0);
    issue("full.push9", 1, OP_PUSH, 9, 8, 8, 1);
    for (int k = 1; k <= DEPTH; k++) issue("full.pop", 1, OP_POP, 0, 8 - k, 8 - k, 0, 1, 9 - k);

    // Underflow
    apply_reset("rst2");
    issue("uf.pop_empty", 1, OP_POP,  0, 0, 0, 1);
    issue("uf.push7",     1, OP_PUSH, 7, 7, 1, 0);
    issue("uf.add1",      1, OP_ADD,  0, 7, 1, 1);
    issue("uf.sub1",      1, OP_SUB,  0, 7, 1, 1);
    issue("uf.idle",      0, OP_NOP,  0, 7, 1, 0);

    // Gated and illegal operations
    apply_reset("rst3");
    issue("ill.push3",   1, OP_PUSH, 3,  3, 1, 0);
    issue("ill.gated",   0, OP_PUSH, 99, 3, 1, 0);
    issue("ill.op6",     1, 3'd6,    99, 3, 1, 1);
    issue("ill.idle",    0, OP_NOP,  0,  3, 1, 0);
    issue("ill.op5",     1, 3'd5,    0,  3, 1, 1);
    issue("ill.op7",     1, 3'd7,    0,  3, 1, 1);
    issue("ill.nop",     1, OP_NOP,  55, 3, 1, 0);

    // Reset mid-sequence, then reuse from empty
    apply_reset("rst4");
    issue("mid.push3", 1, OP_PUSH, 3, 3, 1, 0);
    issue("mid.push4", 1, OP_PUSH, 4, 4, 2, 0);
    apply_reset("rst_mid");
    issue("mid.push_m2", 1, OP_PUSH, -2,   -2,   1, 0);
    issue("mid.push5",   1, OP_PUSH, 5,    5,    2, 0);
    issue("mid.sub",     1, OP_SUB,  0,    -7,   1, 0);
    // SUB overflow: -128 - 1 wraps to 127; entry -7 below must be untouched
    issue("mid.push_min", 1, OP_PUSH, -128, -128, 2, 0);
    issue("mid.push1",    1, OP_PUSH, 1,    1,    3, 0);
    issue("mid.sub_ovf",  1, OP_SUB,  0,    127,  2, 1);
    issue("mid.add",      1, OP_ADD,  0,    120,  1, 0);
    issue("mid.idle",     0, OP_NOP,  0,    120,  1, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    check("drain.pending", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
